// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader: frame FSM states,
// the frame sync byte and the baud divisor calculation.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int calc_div(input int clk_mhz, input int baud_rate);
    return (clk_mhz * 1000000 + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port plus loader status, driven by the loader
// (master) and consumed by the memory / CPU wrapper (slave).
interface uart_program_loader_if #(
  parameter int SIZE = 64
);
  localparam int AW = $clog2(SIZE);

  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [15:0]   words_loaded;

  modport master (
    output im_we, im_waddr, im_wdata, cpu_hold, load_done, load_error, words_loaded
  );

  modport slave (
    input im_we, im_waddr, im_wdata, cpu_hold, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit re-check at half a
// bit, mid-bit sampling LSB first, stop-bit check.
module uart_rx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  rx_state_t      st, st_nxt;
  logic [1:0]     sync;
  logic           rx_s, rx_prev;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic [7:0]     sh, sh_nxt;

  assign rx_s    = sync[1];
  assign rx_byte = sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      sh      <= sh_nxt;
    end
  end

  always_comb begin
    st_nxt      = st;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    sh_nxt      = sh;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    unique case (st)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_s) st_nxt = RX_START;
      end
      // A low pulse shorter than half a bit is rejected here as a glitch.
      RX_START: begin
        if (cnt == CW'(DIV / 2 - 1)) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          st_nxt      = rx_s ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_nxt     = '0;
          sh_nxt      = {rx_s, sh[7:1]};
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) st_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_nxt    = '0;
          st_nxt     = RX_IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default: st_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a checksummed program image from the UART into instruction memory,
// holding the CPU in reset until a complete, verified image has been written.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int clk_mhz    = 50,
  parameter int baud_rate  = 115200,
  parameter int SIZE       = 64,
  parameter int timeout_ms = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  uart_program_loader_if.master bus
);

  localparam int DIV    = calc_div(clk_mhz, baud_rate);
  localparam int AW     = $clog2(SIZE);
  localparam int TO_CYC = timeout_ms * clk_mhz * 1000;
  localparam int TW     = $clog2(TO_CYC + 1);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  state_t        state, state_nxt;
  logic [15:0]   n_words;
  logic [15:0]   n_full;
  logic [1:0]    byte_idx;
  logic [AW-1:0] addr;
  logic [23:0]   word_buf;
  logic [7:0]    sum;
  logic [TW-1:0] to_cnt;
  logic          to_expire;
  logic          start_frame, set_err, write_word, csum_ok, data_byte;

  assign n_full    = {rx_byte, n_words[7:0]};
  assign to_expire = (state != IDLE) && (to_cnt == TW'(TO_CYC));

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    set_err     = 1'b0;
    write_word  = 1'b0;
    csum_ok     = 1'b0;
    data_byte   = 1'b0;
    if (state != IDLE && (frame_err || to_expire)) begin
      set_err   = 1'b1;
      state_nxt = IDLE;
    end else if (byte_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_byte == SYNC_BYTE) begin
            start_frame = 1'b1;
            state_nxt   = CNT_LO;
          end
        end
        CNT_LO: state_nxt = CNT_HI;
        CNT_HI: begin
          if (n_full == 16'd0) begin
            state_nxt = CSUM;
          end else if (n_full > 16'(SIZE)) begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          data_byte = 1'b1;
          if (byte_idx == 2'd3) begin
            write_word = 1'b1;
            if (bus.words_loaded + 16'd1 == n_words) state_nxt = CSUM;
          end
        end
        CSUM: begin
          state_nxt = IDLE;
          if (rx_byte == sum) csum_ok = 1'b1;
          else                set_err = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      to_cnt           <= '0;
      n_words          <= '0;
      byte_idx         <= '0;
      addr             <= '0;
      bus.im_we        <= 1'b0;
      bus.im_waddr     <= '0;
      bus.im_wdata     <= '0;
      bus.cpu_hold     <= 1'b0;
      bus.load_done    <= 1'b0;
      bus.load_error   <= 1'b0;
      bus.words_loaded <= '0;
    end else begin
      state         <= state_nxt;
      to_cnt        <= (state == IDLE || byte_valid) ? '0 : to_cnt + 1'b1;
      bus.im_we     <= write_word;
      bus.load_done <= csum_ok;
      if (byte_valid && state == CNT_LO) n_words[7:0]  <= rx_byte;
      if (byte_valid && state == CNT_HI) n_words[15:8] <= rx_byte;
      if (start_frame) begin
        bus.cpu_hold     <= 1'b1;
        bus.load_error   <= 1'b0;
        bus.words_loaded <= '0;
        addr             <= '0;
        byte_idx         <= '0;
      end
      if (set_err)   bus.load_error <= 1'b1;
      if (csum_ok)   bus.cpu_hold   <= 1'b0;
      if (data_byte) byte_idx       <= byte_idx + 1'b1;
      // addr cannot pass SIZE-1 because N was bounded in CNT_HI.
      if (write_word) begin
        bus.im_waddr     <= addr;
        bus.im_wdata     <= {rx_byte, word_buf};
        addr             <= addr + 1'b1;
        bus.words_loaded <= bus.words_loaded + 16'd1;
      end
    end
  end

  // Datapath: word assembly and running checksum, qualified by control.
  always_ff @(posedge clk) begin
    if (start_frame) sum <= '0;
    if (data_byte) begin
      sum <= sum + rx_byte;
      if (byte_idx != 2'd3) word_buf[8*byte_idx +: 8] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized scoreboard bench for uart_program_loader, run with a shortened
// bit time and timeout so every scenario fits in a short simulation.
module tb_uart_program_loader;

  localparam int CLK_MHZ = 1;
  localparam int BAUD    = 62500;
  localparam int SIZE    = 64;
  localparam int TO_MS   = 1;
  localparam int BIT     = 16;     // 1 MHz / 62500 baud
  localparam int TO_CYC  = 1000;   // 1 ms at 1 MHz
  localparam int AW      = $clog2(SIZE);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;

  uart_program_loader_if #(.SIZE(SIZE)) bus ();

  uart_program_loader #(
    .clk_mhz    (CLK_MHZ),
    .baud_rate  (BAUD),
    .SIZE       (SIZE),
    .timeout_ms (TO_MS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.im_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                   bus.im_waddr, bus.im_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.im_waddr), 32'(e.addr));
          check("wr_data", bus.im_wdata, e.data);
        end
      end
      if (bus.load_done) done_seen++;
    end
  end

  task automatic hold_line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    hold_line(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_line(b[i], BIT);
    hold_line(stop_bit, BIT);
    hold_line(1'b1, 2 * BIT);
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send_byte(bl[i], 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(bus.im_we), 32'd0);
    check({tag, "_waddr"}, 32'(bus.im_waddr), 32'd0);
    check({tag, "_wdata"}, bus.im_wdata, 32'd0);
    check({tag, "_hold"},  32'(bus.cpu_hold), 32'd0);
    check({tag, "_done"},  32'(bus.load_done), 32'd0);
    check({tag, "_err"},   32'(bus.load_error), 32'd0);
    check({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
  endtask

  // Reference: build a frame from a word list, predict every write and the
  // end-of-frame status. csum_ofs != 0 corrupts the checksum by that amount.
  // glitch_after >= 0 inserts a short low pulse after that many bytes.
  task automatic run_frame(input string tag, input logic [31:0] words[$],
                           input logic [7:0] csum_ofs, input int glitch_after);
    logic [7:0] fb[$];
    logic [7:0] s;
    int         n;
    int         d0;
    bit         bad;
    n   = words.size();
    s   = 8'd0;
    bad = (csum_ofs != 8'd0);
    fb  = '{8'hA5, 8'(n), 8'(n >> 8)};
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        fb.push_back(words[i][8*k +: 8]);
        s = s + words[i][8*k +: 8];
      end
      exp_q.push_back('{addr: AW'(i), data: words[i]});
    end
    fb.push_back(s + csum_ofs);
    d0 = done_seen;
    foreach (fb[i]) begin
      send_byte(fb[i], 1'b1);
      if (i == 2) check({tag, "_hold_during"}, 32'(bus.cpu_hold), 32'd1);
      if (i == glitch_after) begin
        hold_line(1'b0, 4);
        hold_line(1'b1, BIT);
      end
    end
    hold_line(1'b1, 4 * BIT);
    check({tag, "_done_cnt"}, 32'(done_seen - d0), bad ? 32'd0 : 32'd1);
    check({tag, "_hold"},     32'(bus.cpu_hold), 32'(bad));
    check({tag, "_err"},      32'(bus.load_error), 32'(bad));
    check({tag, "_words"},    32'(bus.words_loaded), 32'(n));
    check({tag, "_pending"},  32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] rw[$];
    logic [7:0]  bl[$];
    int          d0;

    prog = '{32'h02A00513, 32'h00100593};

    #1;
    check_all_zero("reset");
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_line(1'b1, 4 * BIT);

    // Junk before the sync byte is ignored and the CPU keeps running.
    d0 = done_seen;
    bl = '{8'h00, 8'hFF, 8'h5A};
    send_list(bl);
    hold_line(1'b1, 2 * BIT);
    check("junk_hold", 32'(bus.cpu_hold), 32'd0);
    check("junk_err",  32'(bus.load_error), 32'd0);
    check("junk_done", 32'(done_seen - d0), 32'd0);
    run_frame("t1", prog, 8'd0, -1);

    run_frame("bad_csum", prog, 8'd1, -1);

    // Oversized count.
    bl = '{8'hA5, 8'h41, 8'h00};
    send_list(bl);
    hold_line(1'b1, 4 * BIT);
    check("big_n_err",   32'(bus.load_error), 32'd1);
    check("big_n_hold",  32'(bus.cpu_hold), 32'd1);
    check("big_n_words", 32'(bus.words_loaded), 32'd0);

    // Stalled frame times out.
    bl = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5};
    send_list(bl);
    check("to_early_err", 32'(bus.load_error), 32'd0);
    hold_line(1'b1, TO_CYC + 200);
    check("to_err",   32'(bus.load_error), 32'd1);
    check("to_words", 32'(bus.words_loaded), 32'd0);
    run_frame("after_to", prog, 8'd0, -1);

    // Framing error mid-frame.
    bl = '{8'hA5, 8'h02, 8'h00, 8'h13};
    send_list(bl);
    send_byte(8'h05, 1'b0);
    hold_line(1'b1, 4 * BIT);
    check("ferr_err",  32'(bus.load_error), 32'd1);
    check("ferr_hold", 32'(bus.cpu_hold), 32'd1);

    // A sub-half-bit glitch inside a frame must not become a byte.
    rw = '{32'hA5A5_0F0F};
    run_frame("glitch", rw, 8'd0, 4);

    rw = {};
    run_frame("n_zero", rw, 8'd0, -1);

    // Reset in the middle of the data bytes.
    bl = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
    send_list(bl);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hold", 32'(bus.cpu_hold), 32'd0);
    check_all_zero("mid_rst");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_line(1'b1, 2 * BIT);
    run_frame("after_rst", prog, 8'd0, -1);

    for (int it = 0; it < 5; it++) begin
      int         n;
      logic [7:0] ofs;
      rw  = {};
      n   = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) rw.push_back($urandom());
      ofs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      run_frame($sformatf("rnd%0d", it), rw, ofs, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
